reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Per-architectural-register scoreboard tracking in-flight writes from issue until writeback.
- Supplies the pending bits and writeback-timing rows consumed by issue-stage and decode-stage stall logic.
- Supplies the writeback-slot occupancy column used for the writeback structural-hazard check.
- Sits beside the ARF. Updated by the issue stage and the long-latency completion path.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- ROWW, 5, row width in cycles; maximum fixed latency tracked.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rd_addr_0..rd_addr_4  input  5 each  read addresses: issue a, issue b, decode a, decode b, decode WAW dest
- rd_pending_0..rd_pending_4  output  1 each  pending bit of addressed register
- rd_row_0..rd_row_4  output  ROWW each  timing row of addressed register
- iss_valid  input  1  instruction issues this cycle (not stalled)
- iss_writereg  input  1  issuing instruction writes a register
- iss_writeaddr  input  5  destination register
- iss_long  input  1  unknown latency (load/mul/div); completion signalled via wb_long_*
- iss_latency  input  3  fixed latency L, legal 1..ROWW, ignored when iss_long
- haz_latency  input  3  latency queried for structural check
- haz_column  output  NREGS  per-register writeback-slot conflict bits
- wb_long_valid  input  1  long-latency result written back this cycle
- wb_long_addr  input  5  its destination

Behaviour:
- State per register i: pending[i] (1 bit) and row[i] (ROWW bits, at most one bit set).
- Reset: all pending and row cleared, synchronously on reset at clock edge; overrides any same-cycle issue/wb. All outputs are combinational from state, so they read 0 the cycle after reset.
- Reads: combinational, zero latency. rd_pending_n = pending[rd_addr_n]; rd_row_n = row[rd_addr_n]. Address 0 always reads pending=0, row=0.
- Row semantics: row bit k set means the result reaches the bypass network k cycles after the current one. Bit 0 set means the result is bypassable this cycle.
- Every clock edge, every register whose row is nonzero shifts right by one. This happens unconditionally; pipeline stalls do not freeze the scoreboard.
- A register with row == 1 (bit 0 only) clears both row and pending at the next edge. This applies unless a new issue targets it that cycle.
- Fixed issue, accepted when iss_valid && iss_writereg && !iss_long && addr!=0 && 1<=L<=ROWW:
  - Next edge: pending[addr] <= 1, row[addr] <= 1<<(L-1).
  - L=1 therefore gives row=1 the cycle after issue.
- Long issue (iss_valid && iss_writereg && iss_long, addr!=0):
  - Next edge: pending[addr] <= 1, row[addr] <= 0.
  - Stays pending until a matching wb_long_valid.
- wb_long_valid: next edge clears pending[wb_long_addr] and row[wb_long_addr]. Ignored for addr 0.
- Simultaneous issue and wb_long on the same register: issue wins (new in-flight write).
- Simultaneous issue and natural row expiry on the same register: issue wins.
- Issue to a register already pending: overwrite with the new state. Decode WAW stalling prevents this; no assertion is required.
- Illegal iss_latency (0 or >ROWW) with fixed issue: no state change.
- haz_column[i] = row[i][haz_latency] for 1<=haz_latency<=ROWW-1.
  - Meaning: an existing write currently at bit L lands at bit L-1 next cycle, which is the same slot as a new L-latency write.
  - haz_latency=0 or >=ROWW: haz_column = 0.
  - haz_column[0] is always 0.
- Long-latency entries (row=0) never contribute to haz_column.

Test Plan:
- Reset, then read all addresses -> every rd_pending=0, rd_row=0, haz_column=0. Assert reset during an in-flight L=3 write -> cleared next cycle.
- Issue r5, L=3 at cycle t -> row reads 00100 at t+1, 00010 at t+2, 00001 at t+3; pending 1 through t+3; pending=0, row=0 at t+4.
- Issue r7, long; wb_long_valid r7 at t+6 -> pending=1, row=0 for t+1..t+6; pending=0 at t+7.
- r3 issued L=3 at t. At t+1 query haz_latency=2 -> haz_column=0x00000008. Query haz_latency=3 -> 0. Query haz_latency=0 -> 0.
- Same cycle: issue r4 L=2 and wb_long r4 while r4 long-pending -> next cycle pending=1, row=00010. Issue to r0 -> r0 reads pending=0.
- Five read ports addressing r5 and r9 simultaneously, r5 at L=1 expiry, r9 issued that cycle -> ports return independent correct values. Next cycle r5 cleared, r9 set.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending bit plus a one-hot writeback timing row
// that counts down to the bypass network. Five combinational read ports and a hazard column.
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int ROWW  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           rd_addr_0,
    input  logic [4:0]           rd_addr_1,
    input  logic [4:0]           rd_addr_2,
    input  logic [4:0]           rd_addr_3,
    input  logic [4:0]           rd_addr_4,
    output logic                 rd_pending_0,
    output logic                 rd_pending_1,
    output logic                 rd_pending_2,
    output logic                 rd_pending_3,
    output logic                 rd_pending_4,
    output logic [ROWW-1:0]      rd_row_0,
    output logic [ROWW-1:0]      rd_row_1,
    output logic [ROWW-1:0]      rd_row_2,
    output logic [ROWW-1:0]      rd_row_3,
    output logic [ROWW-1:0]      rd_row_4,
    input  logic                 iss_valid,
    input  logic                 iss_writereg,
    input  logic [4:0]           iss_writeaddr,
    input  logic                 iss_long,
    input  logic [2:0]           iss_latency,
    input  logic [2:0]           haz_latency,
    output logic [NREGS-1:0]     haz_column,
    input  logic                 wb_long_valid,
    input  logic [4:0]           wb_long_addr
);

    logic [NREGS-1:0]           pending_r;
    logic [NREGS-1:0][ROWW-1:0] row_r;
    logic [NREGS-1:0]           pending_nx_s;
    logic [NREGS-1:0][ROWW-1:0] row_nx_s;
    logic                       lat_ok_s;
    logic                       iss_take_s;
    logic [ROWW-1:0]            iss_row_s;

    // Register 0 is hardwired zero, so its reads are forced to zero regardless of state.
    function automatic logic [ROWW:0] read_entry(
        input logic [4:0]                 addr,
        input logic [NREGS-1:0]           pend,
        input logic [NREGS-1:0][ROWW-1:0] rows
    );
        logic [ROWW:0] entry;
        if (addr == 5'd0) begin
            entry = {(ROWW+1){1'b0}};
        end else begin
            entry = {pend[addr], rows[addr]};
        end
        return entry;
    endfunction

    // Decode the issuing instruction into "accepted" and its initial timing row.
    always_comb begin
        lat_ok_s   = (iss_latency != 3'd0) && ({1'b0, iss_latency} <= 4'(ROWW));
        iss_take_s = iss_valid && iss_writereg && (iss_long || lat_ok_s);
        if (iss_long) begin
            iss_row_s = {ROWW{1'b0}};
        end else begin
            iss_row_s = ROWW'(1'b1) << (iss_latency - 3'd1);
        end
    end

    // Next state per register; a new issue beats a same-cycle long writeback or natural expiry.
    always_comb begin
        pending_nx_s = pending_r;
        row_nx_s     = row_r;
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0) begin
                pending_nx_s[i] = 1'b0;
                row_nx_s[i]     = {ROWW{1'b0}};
            end else if (iss_take_s && (iss_writeaddr == 5'(i))) begin
                pending_nx_s[i] = 1'b1;
                row_nx_s[i]     = iss_row_s;
            end else if (wb_long_valid && (wb_long_addr == 5'(i))) begin
                pending_nx_s[i] = 1'b0;
                row_nx_s[i]     = {ROWW{1'b0}};
            end else begin
                row_nx_s[i] = row_r[i] >> 1;
                if (row_r[i] == ROWW'(1'b1)) begin
                    pending_nx_s[i] = 1'b0;
                end else begin
                    pending_nx_s[i] = pending_r[i];
                end
            end
        end
    end

    // State registers; rows advance every edge, stalls do not freeze them.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= {NREGS{1'b0}};
            row_r     <= {(NREGS*ROWW){1'b0}};
        end else begin
            pending_r <= pending_nx_s;
            row_r     <= row_nx_s;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        {rd_pending_0, rd_row_0} = read_entry(rd_addr_0, pending_r, row_r);
        {rd_pending_1, rd_row_1} = read_entry(rd_addr_1, pending_r, row_r);
        {rd_pending_2, rd_row_2} = read_entry(rd_addr_2, pending_r, row_r);
        {rd_pending_3, rd_row_3} = read_entry(rd_addr_3, pending_r, row_r);
        {rd_pending_4, rd_row_4} = read_entry(rd_addr_4, pending_r, row_r);
    end

    // A write now at bit L lands next cycle in the same slot as a new L-latency write.
    always_comb begin
        haz_column = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            for (int k = 1; k < ROWW; k++) begin
                haz_column[i] = haz_column[i] | (row_r[i][k] & (haz_latency == 3'(k)));
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic against a
// countdown-based reference model of in-flight register writes.
module tb_reg_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr [5];
    logic        rd_pending [5];
    logic [4:0]  rd_row [5];
    logic        iss_valid, iss_writereg, iss_long;
    logic [4:0]  iss_writeaddr;
    logic [2:0]  iss_latency, haz_latency;
    logic [31:0] haz_column;
    logic        wb_long_valid;
    logic [4:0]  wb_long_addr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending flag, whether a fixed-latency write is in flight, and cycles until bypass.
    bit m_pend [32];
    bit m_fix  [32];
    int m_due  [32];

    reg_scoreboard dut (
        .clock(clock), .reset(reset),
        .rd_addr_0(rd_addr[0]), .rd_addr_1(rd_addr[1]), .rd_addr_2(rd_addr[2]),
        .rd_addr_3(rd_addr[3]), .rd_addr_4(rd_addr[4]),
        .rd_pending_0(rd_pending[0]), .rd_pending_1(rd_pending[1]), .rd_pending_2(rd_pending[2]),
        .rd_pending_3(rd_pending[3]), .rd_pending_4(rd_pending[4]),
        .rd_row_0(rd_row[0]), .rd_row_1(rd_row[1]), .rd_row_2(rd_row[2]),
        .rd_row_3(rd_row[3]), .rd_row_4(rd_row[4]),
        .iss_valid(iss_valid), .iss_writereg(iss_writereg), .iss_writeaddr(iss_writeaddr),
        .iss_long(iss_long), .iss_latency(iss_latency), .haz_latency(haz_latency),
        .haz_column(haz_column), .wb_long_valid(wb_long_valid), .wb_long_addr(wb_long_addr)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_pend(input logic [4:0] a);
        return (a == 5'd0) ? 1'b0 : m_pend[a];
    endfunction

    function automatic logic [4:0] exp_row(input logic [4:0] a);
        if (a == 5'd0 || !m_fix[a]) return 5'd0;
        return 5'(1 << m_due[a]);
    endfunction

    function automatic logic [31:0] exp_haz(input logic [2:0] hl);
        logic [31:0] col = 32'd0;
        for (int i = 1; i < 32; i++)
            if (m_fix[i] && hl >= 3'd1 && hl <= 3'd4 && m_due[i] == int'(hl)) col[i] = 1'b1;
        return col;
    endfunction

    task automatic model_update();
        int wa = int'(iss_writeaddr);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 1'b0; m_fix[i] = 1'b0; m_due[i] = 0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (m_fix[i]) begin
                    if (m_due[i] == 0) begin m_pend[i] = 1'b0; m_fix[i] = 1'b0; end
                    else m_due[i] = m_due[i] - 1;
                end
            end
            if (wb_long_valid && wb_long_addr != 5'd0) begin
                m_pend[wb_long_addr] = 1'b0; m_fix[wb_long_addr] = 1'b0;
            end
            if (iss_valid && iss_writereg && wa != 0) begin
                if (iss_long) begin
                    m_pend[wa] = 1'b1; m_fix[wa] = 1'b0;
                end else if (iss_latency >= 3'd1 && iss_latency <= 3'd5) begin
                    m_pend[wa] = 1'b1; m_fix[wa] = 1'b1; m_due[wa] = int'(iss_latency) - 1;
                end
            end
        end
    endtask

    // Called at a negedge with inputs driven: check outputs, clock once, advance the model.
    task automatic do_cycle();
        #1;
        for (int p = 0; p < 5; p++) begin
            check_val($sformatf("pend_p%0d_r%0d", p, rd_addr[p]), 32'(rd_pending[p]), 32'(exp_pend(rd_addr[p])));
            check_val($sformatf("row_p%0d_r%0d", p, rd_addr[p]), 32'(rd_row[p]), 32'(exp_row(rd_addr[p])));
        end
        check_val($sformatf("haz_l%0d", haz_latency), haz_column, exp_haz(haz_latency));
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 1'b0; iss_valid = 1'b0; iss_writereg = 1'b0; iss_long = 1'b0;
        wb_long_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic lng, input logic [2:0] lat);
        iss_valid = 1'b1; iss_writereg = 1'b1; iss_writeaddr = a; iss_long = lng; iss_latency = lat;
    endtask

    logic [4:0] seq_row [4];

    initial begin
        idle();
        reset = 1'b1;
        iss_writeaddr = 5'd0; iss_latency = 3'd0; haz_latency = 3'd0; wb_long_addr = 5'd0;
        for (int p = 0; p < 5; p++) rd_addr[p] = 5'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        do_cycle();
        reset = 1'b0;

        // Reset state across every address
        for (int c = 0; c < 7; c++) begin
            for (int p = 0; p < 5; p++) rd_addr[p] = 5'((c * 5 + p) % 32);
            haz_latency = 3'(c);
            do_cycle();
        end
        haz_latency = 3'd0;

        // r5 at L=3 counts down then clears
        seq_row = '{5'b00100, 5'b00010, 5'b00001, 5'b00000};
        rd_addr[0] = 5'd5;
        issue(5'd5, 1'b0, 3'd3);
        do_cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val("r5_l3_row", 32'(rd_row[0]), 32'(seq_row[k]));
            check_val("r5_l3_pend", 32'(rd_pending[0]), (k < 3) ? 32'd1 : 32'd0);
            do_cycle();
        end

        // Reset while an L=3 write is in flight
        issue(5'd5, 1'b0, 3'd3);
        do_cycle();
        idle();
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        #1;
        check_val("rst_inflight_pend", 32'(rd_pending[0]), 32'd0);
        check_val("rst_inflight_row", 32'(rd_row[0]), 32'd0);

        // r7 long, written back at t+6
        rd_addr[0] = 5'd7;
        issue(5'd7, 1'b1, 3'd0);
        do_cycle();
        idle();
        for (int k = 1; k <= 6; k++) begin
            #1;
            check_val("r7_long_pend", 32'(rd_pending[0]), 32'd1);
            check_val("r7_long_row", 32'(rd_row[0]), 32'd0);
            if (k == 6) begin wb_long_valid = 1'b1; wb_long_addr = 5'd7; end
            do_cycle();
        end
        idle();
        #1;
        check_val("r7_after_wb", 32'(rd_pending[0]), 32'd0);

        // Hazard column for r3 at L=3
        issue(5'd3, 1'b0, 3'd3);
        do_cycle();
        idle();
        haz_latency = 3'd2; #1; check_val("haz_l2", haz_column, 32'h0000_0008);
        haz_latency = 3'd3; #1; check_val("haz_l3", haz_column, 32'h0);
        haz_latency = 3'd0; #1; check_val("haz_l0", haz_column, 32'h0);
        repeat (3) do_cycle();

        // Issue beats same-cycle long writeback on r4; writes to r0 are dropped
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd0;
        issue(5'd4, 1'b1, 3'd0);
        do_cycle();
        issue(5'd4, 1'b0, 3'd2);
        wb_long_valid = 1'b1; wb_long_addr = 5'd4;
        do_cycle();
        idle();
        #1;
        check_val("r4_issue_wins_pend", 32'(rd_pending[0]), 32'd1);
        check_val("r4_issue_wins_row", 32'(rd_row[0]), 32'(5'b00010));
        issue(5'd0, 1'b0, 3'd2);
        do_cycle();
        issue(5'd0, 1'b1, 3'd0);
        do_cycle();
        idle();
        #1;
        check_val("r0_pend", 32'(rd_pending[1]), 32'd0);
        check_val("r0_row", 32'(rd_row[1]), 32'd0);

        // Five ports on r5 (expiring) and r9 (issuing) in the same cycle
        issue(5'd5, 1'b0, 3'd1);
        do_cycle();
        issue(5'd9, 1'b0, 3'd4);
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd9; rd_addr[2] = 5'd5; rd_addr[3] = 5'd9; rd_addr[4] = 5'd5;
        #1;
        check_val("mp_r5_pend", 32'(rd_pending[4]), 32'd1);
        check_val("mp_r5_row", 32'(rd_row[2]), 32'd1);
        check_val("mp_r9_pend", 32'(rd_pending[3]), 32'd0);
        do_cycle();
        idle();
        #1;
        check_val("mp_r5_cleared", 32'(rd_pending[0]), 32'd0);
        check_val("mp_r9_pend_next", 32'(rd_pending[1]), 32'd1);
        check_val("mp_r9_row_next", 32'(rd_row[3]), 32'(5'b01000));
        repeat (5) do_cycle();

        // Randomized traffic concentrated on a few registers to force collisions
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            iss_valid     = ($urandom_range(0, 3) != 0);
            iss_writereg  = ($urandom_range(0, 7) != 0);
            iss_long      = ($urandom_range(0, 4) == 0);
            iss_writeaddr = 5'($urandom_range(0, 7));
            iss_latency   = 3'($urandom_range(0, 7));
            wb_long_valid = ($urandom_range(0, 2) == 0);
            wb_long_addr  = 5'($urandom_range(0, 7));
            haz_latency   = 3'($urandom_range(0, 7));
            for (int p = 0; p < 5; p++)
                rd_addr[p] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
